// File: rtl/down_cnt_pkg.sv
// Shared types and limits for the down counter/timer.
package down_cnt_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} down_cnt_state_t;

    localparam int DOWN_CNT_MIN_WIDTH = 2;

endpackage

// File: rtl/tff_n.sv
// T flip-flop toggle cell with asynchronous active-low reset to 0.
module tff_n (
    input  logic T,
    input  logic clk,
    input  logic reset_n,
    output logic Q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q ^ T;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/down_counter_tff.sv
// Programmable down counter/timer built from T flip-flop cells, with expiry pulse and auto-reload.
// Define DOWN_CNT_FREERUN_EN to let the count decrement (and wrap) while IDLE.
module down_counter_tff
    import down_cnt_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             zero,
    output logic             tc
);

    if (WIDTH < DOWN_CNT_MIN_WIDTH) begin : g_width_check
        $error("down_counter_tff: WIDTH must be at least %0d", DOWN_CNT_MIN_WIDTH);
    end

    down_cnt_state_t  state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] borrow_t;
    logic [WIDTH-1:0] count_dec;
    logic [WIDTH-1:0] cell_t;

    // Borrow chain: a bit toggles when every lower bit is already 0.
    always_comb begin
        borrow_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            borrow_t[i] = borrow_t[i-1] & ~count_q[i-1];
        end
        count_dec = count_q ^ borrow_t;
    end

    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        count_d  = count_q;

        if (load) begin
            count_d = load_val;
            if (load_val != '0) begin
                reload_d = load_val;
                state_d  = RUN;
            end else begin
                state_d = IDLE;
                tc_d    = 1'b1;
            end
        end else if (state_q == RUN && en) begin
            if (count_q == WIDTH'(1)) begin
                tc_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end else begin
                count_d = count_dec;
            end
        end
`ifdef DOWN_CNT_FREERUN_EN
        else if (state_q == IDLE && en) begin
            count_d = count_dec;
        end
`endif
    end

    // Parallel writes (load, reload, clear) are folded into the cells as T = Q ^ D.
    assign cell_t = count_q ^ count_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_n u_tff (
            .T       (cell_t[i]),
            .clk     (clk),
            .reset_n (reset_n),
            .Q       (count_q[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign zero  = (count_q == '0);
    assign tc    = tc_q;

endmodule

// File: tb/tb_down_counter_tff.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic vs. a behavioural model.
module tb_down_counter_tff;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;
`ifdef DOWN_CNT_FREERUN_EN
    localparam bit FREERUN = 1'b1;
`else
    localparam bit FREERUN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         en = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] count;
    logic         busy, zero, tc;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int m_cnt    = 0;
    int m_reload = 0;
    bit m_run    = 1'b0;
    bit m_tc     = 1'b0;

    down_counter_tff #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .zero        (zero),
        .tc          (tc)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt = 0; m_reload = 0; m_run = 1'b0; m_tc = 1'b0;
        end else begin
            m_tc = 1'b0;
            if (load) begin
                m_cnt = int'(load_val);
                if (load_val != 0) begin
                    m_reload = int'(load_val);
                    m_run    = 1'b1;
                end else begin
                    m_run = 1'b0;
                    m_tc  = 1'b1;
                end
            end else if (en && m_run) begin
                if (m_cnt == 1) begin
                    m_tc = 1'b1;
                    if (auto_reload) m_cnt = m_reload;
                    else begin m_cnt = 0; m_run = 1'b0; end
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end else if (en && FREERUN) begin
                m_cnt = (m_cnt == 0) ? MAXV : m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (int'(count) != m_cnt || busy != m_run || tc != m_tc || zero != (m_cnt == 0)) begin
                bad++;
                $display("FAIL model t=%0t count=%0d busy=%0b zero=%0b tc=%0b required count=%0d busy=%0b zero=%0b tc=%0b",
                         $time, count, busy, zero, tc, m_cnt, m_run, (m_cnt == 0), m_tc);
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit ld, input int lv, input bit e, input bit ar);
        #1;
        load = ld; load_val = W'(lv); en = e; auto_reload = ar;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int k;
        bit e;
        int ec [9] = '{3, 2, 1, 3, 2, 1, 3, 2, 1};
        bit et [9] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};

        // Reset state
        tick();
        lit("rst_count", int'(count), 0);
        lit("rst_busy", int'(busy), 0);
        lit("rst_zero", int'(zero), 1);
        lit("rst_tc", int'(tc), 0);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;

        // One-shot countdown from 4
        drive(1, 4, 1, 0);
        tick();
        lit("os_load_count", int'(count), 4);
        lit("os_load_busy", int'(busy), 1);
        for (int i = 3; i >= 0; i--) begin
            drive(0, 0, 1, 0);
            tick();
            lit("os_count", int'(count), i);
            lit("os_tc", int'(tc), (i == 0) ? 1 : 0);
            lit("os_busy", int'(busy), (i == 0) ? 0 : 1);
        end
        drive(0, 0, 0, 0);
        tick();
        lit("os_tc_after", int'(tc), 0);

        // Periodic tick with reload 3
        drive(1, 3, 1, 1);
        tick();
        lit("ar_count0", int'(count), ec[0]);
        for (int i = 1; i < 9; i++) begin
            drive(0, 0, 1, 1);
            tick();
            lit("ar_count", int'(count), ec[i]);
            lit("ar_tc", int'(tc), int'(et[i]));
            lit("ar_busy", int'(busy), 1);
        end

        // Stalled countdown from 6
        drive(1, 6, 1, 0);
        tick();
        lit("st_count0", int'(count), 6);
        k = 0;
        for (int i = 0; i < 12; i++) begin
            e = (i % 2) == 1;
            drive(0, 0, e, 0);
            tick();
            if (e) k++;
            lit("st_count", int'(count), 6 - k);
            lit("st_tc", int'(tc), (e && k == 6) ? 1 : 0);
        end

        // Load on the expiry cycle
        drive(1, 2, 1, 0);
        tick();
        drive(0, 0, 1, 0);
        tick();
        lit("le_pre", int'(count), 1);
        drive(1, 9, 1, 0);
        tick();
        lit("le_count", int'(count), 9);
        lit("le_tc", int'(tc), 0);
        lit("le_busy", int'(busy), 1);

        // Load of zero, then enable while idle
        drive(1, 0, 1, 0);
        tick();
        lit("lz_count", int'(count), 0);
        lit("lz_tc", int'(tc), 1);
        lit("lz_busy", int'(busy), 0);
        drive(0, 0, 1, 0);
        tick();
        lit("idle_count1", int'(count), FREERUN ? 15 : 0);
        lit("idle_tc1", int'(tc), 0);
        drive(0, 0, 1, 0);
        tick();
        lit("idle_count2", int'(count), FREERUN ? 14 : 0);
        lit("idle_busy", int'(busy), 0);

        // Asynchronous reset mid-run
        drive(1, 5, 0, 0);
        tick();
        lit("ar_pre", int'(count), 5);
        drive(0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        lit("amid_count", int'(count), 0);
        lit("amid_busy", int'(busy), 0);
        lit("amid_tc", int'(tc), 0);
        lit("amid_zero", int'(zero), 1);
        tick();
        #1 reset_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 8), int'($urandom_range(0, MAXV)),
                  ($urandom_range(0, 99) < 70), ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 199) == 0) begin
                #2 reset_n = 1'b0;
                #4 reset_n = 1'b1;
            end
            tick();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
